// File: rtl/sha256_pkg.sv
// SHA-256 round controller shared definitions.
// Round constants, initial hash value, FSM encoding and word types.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [7:0][WORD_W-1:0] hash_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_ACCUM,
    S_DONE
  } state_e;

  // H0 sits in the top word
  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:ROUNDS-1][WORD_W-1:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round constant ROM.
// Purely combinational lookup of K[idx].
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0] idx_i,
  output word_t      k_o
);

  assign k_o = K_TAB[idx_i];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 per-block round sequencer.
// Owns the FSM, round counter and the H0..H7 digest bank.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         INIT,
  input  logic         W_VALID,
  input  logic [31:0]  W_DATA,
  output logic         W_READY,
  input  logic [255:0] WORK_IN,
  output logic         LOAD,
  output logic         RND_EN,
  output logic [5:0]   RND_I,
  output logic [31:0]  K_OUT,
  output logic [31:0]  W_OUT,
  output logic [255:0] H_OUT,
  output logic         BUSY,
  output logic         DIGEST_VALID
);

  state_e     state_q, state_d;
  logic [5:0] rnd_q, rnd_d;
  hash_t      h_q, h_d;
  hash_t      work;
  logic       early;

  assign work  = WORK_IN;
  assign early = (rnd_q[5:4] == 2'b00);
  assign RND_I = rnd_q;
  assign H_OUT = h_q;

  sha256_k_rom u_k_rom (
    .idx_i (rnd_q),
    .k_o   (K_OUT)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (START) state_d = S_LOAD;
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: begin
        if (RND_EN && rnd_q == 6'd63)
          state_d = S_ACCUM;
      end
      S_ACCUM: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    LOAD         = 1'b0;
    RND_EN       = 1'b0;
    W_READY      = 1'b0;
    W_OUT        = '0;
    BUSY         = 1'b1;
    DIGEST_VALID = 1'b0;
    unique case (state_q)
      S_IDLE:  BUSY = 1'b0;
      S_LOAD:  LOAD = 1'b1;
      S_ROUND: begin
        W_READY = early;
        RND_EN  = early ? W_VALID : 1'b1;
        W_OUT   = early ? W_DATA : '0;
      end
      S_DONE:  DIGEST_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rnd_q <= '0;
      h_q   <= IV;
    end else begin
      rnd_q <= rnd_d;
      h_q   <= h_d;
    end
  end

  // counter wraps 63->0 on the last round
  always_comb begin
    rnd_d = rnd_q;
    h_d   = h_q;
    if (RND_EN)
      rnd_d = rnd_q + 6'd1;
    if (state_q == S_IDLE && START && INIT)
      h_d = IV;
    if (state_q == S_ACCUM) begin
      for (int i = 0; i < 8; i++)
        h_d[i] = h_q[i] + work[i];
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: models the round compressor around it
// and checks digests against a plain SHA-256 block reference.
module tb_sha256_round_ctrl;

  logic         CLK = 1'b0;
  logic         RESET, START, INIT, W_VALID;
  logic [31:0]  W_DATA;
  logic         W_READY, LOAD, RND_EN, BUSY, DIGEST_VALID;
  logic [255:0] WORK_IN, H_OUT;
  logic [5:0]   RND_I;
  logic [31:0]  K_OUT, W_OUT;

  sha256_round_ctrl dut (
    .CLK(CLK), .RESET(RESET), .START(START), .INIT(INIT),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .WORK_IN(WORK_IN), .LOAD(LOAD), .RND_EN(RND_EN),
    .RND_I(RND_I), .K_OUT(K_OUT), .W_OUT(W_OUT),
    .H_OUT(H_OUT), .BUSY(BUSY), .DIGEST_VALID(DIGEST_VALID)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_TB = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] ABC [16] = '{
    32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018
  };
  localparam logic [31:0] M1 [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [31:0] M2 [16] = '{
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0
  };
  localparam logic [255:0] ABC_DIG = {
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [255:0] TWO_DIG = {
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] rnd_fn(input logic [255:0] s,
                                          input logic [31:0] k,
                                          input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
           + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] sha_block(input logic [255:0] h,
                                             input logic [31:0] m [16]);
    logic [31:0]  w [64];
    logic [255:0] s, r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    s = h;
    for (int t = 0; t < 64; t++) s = rnd_fn(s, KT[t], w[t]);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + s[32*i +: 32];
    return r;
  endfunction

  // compressor + W schedule environment driven by the DUT
  logic [255:0] ws;
  logic [31:0]  ew [64];
  logic [31:0]  env_wt;
  assign WORK_IN = ws;

  always_comb begin
    if (RND_I < 6'd16) env_wt = W_OUT;
    else env_wt = ss1(ew[RND_I - 6'd2]) + ew[RND_I - 6'd7]
                + ss0(ew[RND_I - 6'd15]) + ew[RND_I - 6'd16];
  end

  always @(posedge CLK) begin
    if (LOAD) ws <= H_OUT;
    else if (RND_EN) begin
      ew[RND_I] <= env_wt;
      ws <= rnd_fn(ws, K_OUT, env_wt);
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0]  blk [16];
  logic [255:0] model_h, exp_h;
  logic [31:0]  k63;
  int           got_lat, got_stalls;
  bit           got_dv, aborted;

  task automatic do_reset();
    RESET = 1; START = 0; INIT = 0; W_VALID = 0; W_DATA = '0;
    repeat (2) @(negedge CLK);
    RESET = 0;
    model_h = IV_TB;
  endtask

  // mode 0: no stalls, 1: random stalls, 2: stall_n cycles at word 5
  task automatic run_block(input bit init, input int mode, input int stall_n,
                           input bit spam, input int rst_rnd, input string tag);
    int         n, stalls;
    bit         prev_stall, stall;
    logic [5:0] prev_rnd;
    got_dv = 0; aborted = 0; got_lat = -1;
    stalls = 0; prev_stall = 0; prev_rnd = '0;
    exp_h = sha_block(init ? IV_TB : model_h, blk);
    @(negedge CLK);
    n = cyc; START = 1; INIT = init; W_VALID = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      START = 0;
      INIT = 1'($urandom_range(0, 1));
      if (prev_stall) chk({tag, "_stall_hold"}, RND_I, prev_rnd);
      if (BUSY) chk({tag, "_k_out"}, K_OUT, KT[RND_I]);
      if (BUSY && RND_I >= 6'd16) chk({tag, "_w_out_zero"}, W_OUT, 0);
      if (RND_EN && RND_I == 6'd63) k63 = K_OUT;
      if (rst_rnd >= 0 && RND_EN && int'(RND_I) == rst_rnd) begin
        RESET = 1;
        @(negedge CLK);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_h_iv"}, H_OUT, IV_TB);
        chk({tag, "_rnd0"}, RND_I, 0);
        chk({tag, "_rnd_en"}, RND_EN, 0);
        RESET = 0;
        model_h = IV_TB;
        aborted = 1;
        break;
      end
      if (DIGEST_VALID) begin
        got_dv = 1;
        got_lat = cyc - n;
        if (spam) begin START = 1; INIT = 1; end
        break;
      end
      if (spam && BUSY && (RND_I == 6'd10 || RND_I == 6'd63)) begin
        START = 1; INIT = 1;
      end
      if (mode == 1) stall = W_READY && ($urandom_range(0, 3) == 0);
      else stall = W_READY && mode == 2 && RND_I == 6'd5 && stalls < stall_n;
      if (stall) stalls++;
      W_VALID = W_READY ? !stall : 1'($urandom_range(0, 1));
      W_DATA = (RND_I < 6'd16) ? blk[RND_I[3:0]] : $urandom;
      prev_stall = stall;
      prev_rnd = RND_I;
    end
    got_stalls = stalls;
    if (!aborted) begin
      chk({tag, "_dv_seen"}, got_dv, 1);
      if (got_dv) begin
        chk({tag, "_latency"}, got_lat, 67 + stalls);
        chk({tag, "_model"}, H_OUT, exp_h);
        model_h = exp_h;
      end
    end
    @(negedge CLK);
    START = 0;
  endtask

  initial begin
    int busy_cnt, dv_cnt;
    do_reset();
    chk("rst_busy", BUSY, 0);
    chk("rst_load", LOAD, 0);
    chk("rst_rnd_en", RND_EN, 0);
    chk("rst_w_ready", W_READY, 0);
    chk("rst_dv", DIGEST_VALID, 0);
    chk("rst_rnd_i", RND_I, 0);
    chk("rst_h", H_OUT, IV_TB);
    chk("rst_k0", K_OUT, 32'h428a2f98);

    blk = ABC;
    run_block(1, 0, 0, 0, -1, "abc");
    chk("abc_digest", H_OUT, ABC_DIG);
    chk("abc_lat67", got_lat, 67);
    chk("abc_dv_pulse", DIGEST_VALID, 0);
    chk("abc_idle", BUSY, 0);
    chk("k63", k63, 32'hc67178f2);

    blk = M1;
    run_block(1, 0, 0, 0, -1, "two_b1");
    blk = M2;
    run_block(0, 0, 0, 0, -1, "two_b2");
    chk("two_digest", H_OUT, TWO_DIG);

    blk = ABC;
    run_block(1, 2, 3, 0, -1, "stall");
    chk("stall_digest", H_OUT, ABC_DIG);
    chk("stall_lat70", got_lat, 70);

    run_block(1, 0, 0, 0, 30, "rst30");
    chk("rst30_aborted", aborted, 1);
    run_block(1, 0, 0, 0, -1, "post_rst");
    chk("post_rst_digest", H_OUT, ABC_DIG);

    run_block(1, 0, 0, 1, -1, "spam");
    chk("spam_digest", H_OUT, ABC_DIG);
    busy_cnt = 0; dv_cnt = 0;
    repeat (80) begin
      @(negedge CLK);
      if (BUSY) busy_cnt++;
      if (DIGEST_VALID) dv_cnt++;
    end
    chk("spam_no_busy", busy_cnt, 0);
    chk("spam_no_dv", dv_cnt, 0);
    chk("spam_h_hold", H_OUT, ABC_DIG);
    chk("idle_rnd0", RND_I, 0);
    chk("idle_k0", K_OUT, 32'h428a2f98);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_block(1'($urandom_range(0, 1)), 1, 0, 0, -1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
